// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and constants for the
// multi-precision add sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int BYTE_W      = 8;
  localparam int ADD_LAT_DEF = 2;

endpackage

// File: rtl/mp_add_seq.sv
// mp_add_seq: byte-serial multi-precision add via external carry-select adder.
// Optional signed overflow output enabled by macro MP_ADD_OVF_EN.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS   = 4,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Start,
  input  logic [BYTE_W*WORDS-1:0] OpA,
  input  logic [BYTE_W*WORDS-1:0] OpB,
  input  logic                    CinIn,
  output logic                    Busy,
  output logic                    Done,
  output logic [BYTE_W*WORDS-1:0] Result,
  output logic                    CoutOut,
  output logic                    Ovf,
  output logic [BYTE_W-1:0]       AddA,
  output logic [BYTE_W-1:0]       AddB,
  output logic                    AddCin,
  input  logic [BYTE_W-1:0]       AddS,
  input  logic                    AddCout
);

  localparam int W  = BYTE_W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  opa_q;
  logic [W-1:0]  opb_q;
  logic          carry_q;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          smp;
  logic          last;

  // adder inputs come straight from registers so they hold through WAIT
  assign AddA   = opa_q[idx*BYTE_W +: BYTE_W];
  assign AddB   = opb_q[idx*BYTE_W +: BYTE_W];
  assign AddCin = carry_q;

  assign Busy = (state == S_ISSUE) || (state == S_WAIT);
  assign Done = (state == S_DONE);

  // state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state plus accept/sample strobes for the datapath
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    smp      = 1'b0;
    last     = (idx == IW'(WORDS - 1));
    case (state)
      S_IDLE: begin
        if (Start) begin
          accept   = 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CW'(ADD_LAT - 1)) begin
          smp      = 1'b1;
          state_nx = last ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // operand latch, byte walk, carry chain and sum assembly
  always_ff @(posedge Clk) begin
    if (Rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      Result  <= '0;
      CoutOut <= 1'b0;
    end else begin
      if (accept) begin
        opa_q   <= OpA;
        opb_q   <= OpB;
        carry_q <= CinIn;
        idx     <= '0;
        Result  <= '0;
        CoutOut <= 1'b0;
      end
      if (state == S_ISSUE) begin
        cnt <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + CW'(1);
      end
      if (smp) begin
        Result[idx*BYTE_W +: BYTE_W] <= AddS;
        carry_q <= AddCout;
        if (last) begin
          CoutOut <= AddCout;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

`ifdef MP_ADD_OVF_EN
  // signed overflow from the top byte, held and cleared with Result
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Ovf <= 1'b0;
    end else if (accept) begin
      Ovf <= 1'b0;
    end else if (smp && last) begin
      Ovf <= (opa_q[W-1] == opb_q[W-1]) &&
             (AddS[BYTE_W-1] != opa_q[W-1]);
    end
  end
`else
  assign Ovf = 1'b0;
`endif

endmodule
